// File: rtl/mips_multi_param_if.sv
// Memory-side bus of mips_multi_param: an instruction fetch port and a data
// access port, each with a request/ready handshake that tolerates wait states.
//   imem_addr/imem_req      core -> instruction memory (word address, request)
//   imem_rdata/imem_ready   instruction memory -> core
//   dmem_addr/dmem_wdata/dmem_we/dmem_req   core -> data memory
//   dmem_rdata/dmem_ready   data memory -> core
interface mips_multi_param_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_req;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_we;
  logic              dmem_req;
  logic [31:0]       dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_addr, imem_req, dmem_addr, dmem_wdata, dmem_we, dmem_req,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_addr, imem_req, dmem_addr, dmem_wdata, dmem_we, dmem_req,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mips_multi_param.sv
// Parametrised multicycle MIPS core (RST/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Instruction and data memories are external, reached through bus (master).
// Ports:
//   clock, reset_n   core clock; asynchronous active-low reset
//   bus              instruction/data memory handshakes
//   dbg_sel/dbg_data combinational register-file read port (index 0 reads 0)
//   halted           high while in HALT
//   illegal          sticky undecoded opcode/funct flag, cleared only by reset
//   state            current FSM state encoding
module mips_multi_param #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  mips_multi_param_if.master  bus,
  input  logic [4:0]          dbg_sel,
  output logic [31:0]         dbg_data,
  output logic                halted,
  output logic                illegal,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpHalt  = 6'b111111;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;   // ALUOut; low bits double as the data address
  logic [31:0]       mdr_q, mdr_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       regs_q [32];
  logic [31:0]       regs_d [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];

  // Logical immediates are zero-extended, everything else sign-extended.
  assign imm_ext = (opcode == OpAndi || opcode == OpOri) ? {16'h0000, ir_q[15:0]}
                                                        : {{16{ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_q;

    unique case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        state_d = (opcode == OpHalt) ? StHalt : StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (opcode)
          OpRtype: begin
            state_d = StWb;
            case (funct)
              FnAdd:   alu_d = a_q + b_q;
              FnSub:   alu_d = a_q - b_q;
              FnAnd:   alu_d = a_q & b_q;
              FnOr:    alu_d = a_q | b_q;
              FnSlt:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
              default: begin
                illegal_d = 1'b1;
                state_d   = StFetch;
              end
            endcase
          end
          OpAddi: begin
            alu_d   = a_q + imm_ext;
            state_d = StWb;
          end
          OpAndi: begin
            alu_d   = a_q & imm_ext;
            state_d = StWb;
          end
          OpOri: begin
            alu_d   = a_q | imm_ext;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            alu_d   = a_q + imm_ext;
            state_d = StMem;
          end
          // PC has already been incremented in FETCH.
          OpBeq: if (a_q == b_q) pc_d = pc_q + imm_ext[ADDR_W-1:0];
          OpBne: if (a_q != b_q) pc_d = pc_q + imm_ext[ADDR_W-1:0];
          OpJ:   pc_d = ir_q[ADDR_W-1:0];
          default: illegal_d = 1'b1;
        endcase
      end
      StMem: begin
        if (bus.dmem_ready) begin
          if (opcode == OpLw) begin
            mdr_d   = bus.dmem_rdata;
            state_d = StWb;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        rf_we = 1'b1;
        if (opcode == OpRtype) begin
          rf_waddr = rd;
        end else if (opcode == OpLw) begin
          rf_wdata = mdr_q;
        end
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (rf_we && rf_waddr != 5'd0) begin
      regs_d[rf_waddr] = rf_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRst;
      pc_q      <= ResetPc;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  // Strobes decode straight from state so reset kills them asynchronously.
  assign bus.imem_addr  = pc_q;
  assign bus.imem_req   = (state_q == StFetch);
  assign bus.dmem_req   = (state_q == StMem);
  assign bus.dmem_we    = (state_q == StMem) && (opcode == OpSw);
  assign bus.dmem_addr  = alu_q[ADDR_W-1:0];
  assign bus.dmem_wdata = b_q;

  assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : regs_q[dbg_sel];
  assign halted   = (state_q == StHalt);
  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_multi_param.sv
module tb_mips_multi_param;

  localparam int unsigned AW = 4;

  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [31:0] Halt  = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] dbg_data;
  logic        halted;
  logic        illegal;
  logic [2:0]  state;

  logic [31:0] imem [16];
  logic [31:0] dmem [16];
  int iwait = 0;
  int dwait = 0;
  int icnt = 0;
  int dcnt = 0;

  int tests = 0;
  int failed = 0;

  mips_multi_param_if #(.ADDR_W(AW)) bus ();

  mips_multi_param #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .halted   (halted),
    .illegal  (illegal),
    .state    (state)
  );

  always #5 clock = ~clock;

  // Memory model: ready after <wait> stalled cycles of a held request.
  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.imem_ready = bus.imem_req && (icnt >= iwait);
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  assign bus.dmem_ready = bus.dmem_req && (dcnt >= dwait);

  always @(posedge clock) begin
    if (bus.imem_req && !bus.imem_ready) icnt <= icnt + 1;
    else icnt <= 0;
    if (bus.dmem_req && !bus.dmem_ready) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
    end else if (bus.dmem_we && bus.dmem_ready) begin
      dmem[bus.dmem_addr] <= bus.dmem_wdata;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {OpJ, tgt};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [4:0]  sel;
    logic [31:0] exp_reg;
    logic        exp_ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = Halt;
  endtask

  // Leaves the bench at a negedge with the core in RST (cycle 0).
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic wait_fetch(input string name);
    int n;
    n = 0;
    while (state != 3'd1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  vec_t vecs [13];
  logic [31:0] nop;
  logic [31:0] loop3;
  logic [2:0]  exp_st [9];
  logic        exp_rq [9];

  initial begin
    nop   = enc_i(OpAddi, 5'd0, 5'd0, 16'h0000);
    loop3 = enc_i(OpBeq, 5'd0, 5'd0, 16'hFFFF);

    vecs[0]  = '{"add", enc_i(OpAddi, 0, 1, 16'd5), enc_r(1, 1, 2, 6'b100000), nop,
                 5'd2, 32'd10, 1'b0};
    vecs[1]  = '{"sub", enc_i(OpAddi, 0, 1, 16'd7), enc_i(OpAddi, 0, 2, 16'd9),
                 enc_r(1, 2, 3, 6'b100010), 5'd3, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{"and", enc_i(OpAddi, 0, 1, 16'd12), enc_i(OpAddi, 0, 2, 16'd10),
                 enc_r(1, 2, 3, 6'b100100), 5'd3, 32'd8, 1'b0};
    vecs[3]  = '{"or", enc_i(OpAddi, 0, 1, 16'd12), enc_i(OpAddi, 0, 2, 16'd10),
                 enc_r(1, 2, 3, 6'b100101), 5'd3, 32'd14, 1'b0};
    vecs[4]  = '{"slt_neg", enc_i(OpAddi, 0, 5, 16'hFFFF), enc_i(OpAddi, 0, 6, 16'd1),
                 enc_r(5, 6, 4, 6'b101010), 5'd4, 32'd1, 1'b0};
    vecs[5]  = '{"slt_pos", enc_i(OpAddi, 0, 5, 16'hFFFF), enc_i(OpAddi, 0, 6, 16'd1),
                 enc_r(6, 5, 4, 6'b101010), 5'd4, 32'd0, 1'b0};
    vecs[6]  = '{"andi_zext", enc_i(OpAddi, 0, 1, 16'hFFFF), enc_i(OpAndi, 1, 2, 16'h8001),
                 nop, 5'd2, 32'h0000_8001, 1'b0};
    vecs[7]  = '{"ori_zext", enc_i(OpAddi, 0, 1, 16'h0010), enc_i(OpOri, 1, 2, 16'hF000),
                 nop, 5'd2, 32'h0000_F010, 1'b0};
    vecs[8]  = '{"r0_discard", enc_i(OpAddi, 0, 0, 16'd9), enc_r(0, 0, 1, 6'b100000), nop,
                 5'd1, 32'd0, 1'b0};
    vecs[9]  = '{"sw_lw", enc_i(OpAddi, 0, 1, 16'd5), enc_i(OpSw, 0, 1, 16'd4),
                 enc_i(OpLw, 0, 3, 16'd4), 5'd3, 32'd5, 1'b0};
    vecs[10] = '{"ill_opcode", {6'b010000, 26'd0}, enc_i(OpAddi, 0, 1, 16'd5), nop,
                 5'd1, 32'd5, 1'b1};
    vecs[11] = '{"ill_funct", enc_r(0, 0, 0, 6'b000111), enc_i(OpAddi, 0, 1, 16'd5), nop,
                 5'd1, 32'd5, 1'b1};
    vecs[12] = '{"add_wrap", enc_i(OpAddi, 0, 1, 16'hFFFF), enc_r(1, 1, 2, 6'b100000), nop,
                 5'd2, 32'hFFFF_FFFE, 1'b0};

    // Table: three instructions then a self-loop at word 3.
    for (int v = 0; v < 13; v++) begin
      clear_imem();
      imem[0] = vecs[v].i0;
      imem[1] = vecs[v].i1;
      imem[2] = vecs[v].i2;
      imem[3] = loop3;
      do_reset();
      repeat (25) step();
      dbg_sel = vecs[v].sel;
      #1;
      check({vecs[v].name, "_reg"}, dbg_data, vecs[v].exp_reg);
      check({vecs[v].name, "_illegal"}, {31'd0, illegal}, {31'd0, vecs[v].exp_ill});
    end

    // Cycle-exact zero-wait trace of addi then add.
    clear_imem();
    imem[0] = enc_i(OpAddi, 0, 1, 16'd5);
    imem[1] = enc_r(1, 1, 2, 6'b100000);
    imem[2] = enc_i(OpBeq, 0, 0, 16'hFFFF);
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd5};
    exp_rq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_imem_addr", {28'd0, bus.imem_addr}, 32'd0);
    check("rst_strobes", {29'd0, bus.imem_req, bus.dmem_req, bus.dmem_we}, 32'd0);
    check("rst_flags", {30'd0, halted, illegal}, 32'd0);
    for (int c = 1; c < 9; c++) begin
      step();
      check($sformatf("trace_state_c%0d", c), {29'd0, state}, {29'd0, exp_st[c]});
      check($sformatf("trace_ireq_c%0d", c), {31'd0, bus.imem_req}, {31'd0, exp_rq[c]});
    end
    check("trace_pc_c8", {28'd0, bus.imem_addr}, 32'd2);
    step();
    dbg_sel = 5'd2;
    #1;
    check("trace_r2", dbg_data, 32'd10);

    // Fetch with three wait cycles.
    clear_imem();
    imem[0] = enc_i(OpAddi, 0, 1, 16'd5);
    imem[1] = enc_i(OpBeq, 0, 0, 16'hFFFF);
    iwait = 3;
    do_reset();
    for (int c = 1; c < 5; c++) begin
      step();
      check($sformatf("iwait_state_c%0d", c), {29'd0, state}, 32'd1);
      check($sformatf("iwait_addr_c%0d", c), {28'd0, bus.imem_addr}, 32'd0);
    end
    step();
    check("iwait_decode_c5", {29'd0, state}, 32'd2);
    step();
    step();
    check("iwait_wb_c7", {29'd0, state}, 32'd5);
    iwait = 0;

    // sw then lw with two data wait cycles.
    begin
      int we_cnt;
      int bad;
      clear_imem();
      imem[0] = enc_i(OpAddi, 0, 1, 16'd5);
      imem[1] = enc_i(OpSw, 0, 1, 16'd4);
      imem[2] = enc_i(OpLw, 0, 3, 16'd4);
      imem[3] = loop3;
      dwait = 2;
      we_cnt = 0;
      bad = 0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
        step();
        if (bus.dmem_we) begin
          we_cnt++;
          if (state != 3'd4 || bus.dmem_addr != 4'd4 || bus.dmem_wdata != 32'd5) bad++;
        end
      end
      check("dwait_we_cycles", we_cnt, 32'd3);
      check("dwait_we_bad", bad, 32'd0);
      check("dwait_mem4", dmem[4], 32'd5);
      dbg_sel = 5'd3;
      #1;
      check("dwait_r3", dbg_data, 32'd5);
      dwait = 0;
    end

    // Branch and jump targets.
    begin
      int at7;
      int stray;
      clear_imem();
      imem[0] = enc_j(26'd7);
      imem[7] = enc_i(OpBeq, 0, 0, 16'hFFFF);
      at7 = 0;
      stray = 0;
      do_reset();
      for (int c = 0; c < 30; c++) begin
        step();
        if (state == 3'd1) begin
          if (bus.imem_addr == 4'd7) at7++;
          else if (bus.imem_addr != 4'd0) stray++;
        end
      end
      check("beq_loop_hits", {31'd0, at7 >= 4}, 32'd1);
      check("beq_loop_stray", stray, 32'd0);
    end

    clear_imem();
    imem[0] = enc_j(26'd7);
    imem[7] = enc_i(OpBne, 0, 0, 16'hFFFF);
    imem[8] = enc_i(OpBeq, 0, 0, 16'hFFFF);
    do_reset();
    repeat (20) step();
    wait_fetch("bne");
    check("bne_fallthrough_pc", {28'd0, bus.imem_addr}, 32'd8);

    clear_imem();
    imem[0]  = enc_j(26'h3FF_FFFF);
    imem[15] = enc_i(OpBeq, 0, 0, 16'hFFFF);
    do_reset();
    repeat (20) step();
    wait_fetch("jmax");
    check("j_truncated_pc", {28'd0, bus.imem_addr}, 32'd15);

    // Halt is terminal and issues no requests.
    begin
      int reqs;
      clear_imem();
      imem[0] = enc_i(OpAddi, 0, 1, 16'd5);
      imem[1] = Halt;
      do_reset();
      repeat (10) step();
      reqs = 0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (bus.imem_req || bus.dmem_req) reqs++;
      end
      check("halt_state", {29'd0, state}, 32'd6);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_no_req", reqs, 32'd0);
      dbg_sel = 5'd1;
      #1;
      check("halt_r1", dbg_data, 32'd5);
    end

    // Reset during a stalled store.
    begin
      int n;
      clear_imem();
      imem[0] = enc_i(OpAddi, 0, 1, 16'd5);
      imem[1] = enc_i(OpSw, 0, 1, 16'd4);
      dwait = 20;
      do_reset();
      n = 0;
      while (!bus.dmem_we && n < 40) begin
        step();
        n++;
      end
      check("mrst_reached_mem", {31'd0, bus.dmem_we}, 32'd1);
      step();
      #2;
      reset_n = 1'b0;
      #1;
      dbg_sel = 5'd1;
      #1;
      check("mrst_we", {31'd0, bus.dmem_we}, 32'd0);
      check("mrst_req", {31'd0, bus.dmem_req}, 32'd0);
      check("mrst_state", {29'd0, state}, 32'd0);
      check("mrst_r1", dbg_data, 32'd0);
      check("mrst_mem4", dmem[4], 32'd0);
      dwait = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
